// File: rtl/ifetch_pkg.sv
// Shared fetch-path constants: default widths, reset PC and buffer depth.
// Imported by ifetch, its buffer, and the neighbouring ROM/decode blocks.
package ifetch_pkg;

    localparam int unsigned IF_AWIDTH     = 16;
    localparam int unsigned IF_DWIDTH     = 16;
    localparam int unsigned IF_RESET_PC   = 0;
    localparam int unsigned IF_FIFO_DEPTH = 2;

    typedef logic [$clog2(IF_FIFO_DEPTH + 1)-1:0] if_cnt_t;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry registered FIFO of {pc, instruction} pairs between the ROM response
// and decode; the head is held in registers so decode sees no ROM timing.
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int unsigned AWIDTH = IF_AWIDTH,
    parameter int unsigned DWIDTH = IF_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [AWIDTH-1:0] push_pc_i,
    input  logic [DWIDTH-1:0] push_inst_i,
    output if_cnt_t           count_o,
    output logic              head_valid_o,
    output logic [AWIDTH-1:0] head_pc_o,
    output logic [DWIDTH-1:0] head_inst_o
);

    logic [AWIDTH-1:0] headPc_q, headPc_d, tailPc_q, tailPc_d;
    logic [DWIDTH-1:0] headInst_q, headInst_d, tailInst_q, tailInst_d;
    if_cnt_t           count_q, count_d;

    // A new entry lands in the head when the FIFO is (or becomes) empty,
    // otherwise in the tail; a pop always promotes the tail.
    always_comb begin
        headPc_d   = headPc_q;
        headInst_d = headInst_q;
        tailPc_d   = tailPc_q;
        tailInst_d = tailInst_q;
        count_d    = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == '0) begin
                        headPc_d   = push_pc_i;
                        headInst_d = push_inst_i;
                    end else begin
                        tailPc_d   = push_pc_i;
                        tailInst_d = push_inst_i;
                    end
                    count_d = count_q + if_cnt_t'(1);
                end
                2'b01: begin
                    headPc_d   = tailPc_q;
                    headInst_d = tailInst_q;
                    count_d    = count_q - if_cnt_t'(1);
                end
                2'b11: begin
                    if (count_q == if_cnt_t'(1)) begin
                        headPc_d   = push_pc_i;
                        headInst_d = push_inst_i;
                    end else begin
                        headPc_d   = tailPc_q;
                        headInst_d = tailInst_q;
                        tailPc_d   = push_pc_i;
                        tailInst_d = push_inst_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPc_q   <= '0;
            headInst_q <= '0;
            tailPc_q   <= '0;
            tailInst_q <= '0;
            count_q    <= '0;
        end else begin
            headPc_q   <= headPc_d;
            headInst_q <= headInst_d;
            tailPc_q   <= tailPc_d;
            tailInst_q <= tailInst_d;
            count_q    <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_pc_o    = headPc_q;
    assign head_inst_o  = headInst_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues ROM requests, buffers responses and
// hands {pc, inst} to decode; a redirect flushes everything from the old stream.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int unsigned       AWIDTH   = IF_AWIDTH,
    parameter int unsigned       DWIDTH   = IF_DWIDTH,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(IF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic [AWIDTH-1:0] rom_addr,
    output logic              rom_ready,
    input  logic [DWIDTH-1:0] rom_dout,
    input  logic              rom_valid,
    output logic [DWIDTH-1:0] inst,
    output logic [AWIDTH-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready
);

    logic [AWIDTH-1:0] pc_q, pc_d, reqPc_q, reqPc_d;
    logic              issued_q, issued_d, inFlight_q, inFlight_d;
    logic              headValid, pop, push, pushExpected;
    logic [2:0]        nextOcc;
    if_cnt_t           bufCount;

    // The issue decision uses the registered in-flight bit rather than
    // rom_valid, so no combinational path runs from the ROM back to rom_ready.
    always_comb begin
        inst_valid   = headValid & ~redirect_valid;
        pop          = inst_valid & inst_ready;
        push         = rom_valid & issued_q & ~redirect_valid;
        pushExpected = inFlight_q & ~redirect_valid;
        nextOcc      = {1'b0, bufCount} + {2'b00, pushExpected} - {2'b00, pop};
        rom_addr     = redirect_valid ? redirect_pc : pc_q;
        rom_ready    = rst_n & fetch_en & (redirect_valid | (nextOcc <= 3'd1));
    end

    always_comb begin
        pc_d       = pc_q;
        reqPc_d    = reqPc_q;
        issued_d   = issued_q | rom_ready;
        inFlight_d = rom_ready;
        if (rom_ready) begin
            reqPc_d = rom_addr;
            pc_d    = rom_addr + AWIDTH'(1);
        end else if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            reqPc_q    <= '0;
            issued_q   <= 1'b0;
            inFlight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            reqPc_q    <= reqPc_d;
            issued_q   <= issued_d;
            inFlight_q <= inFlight_d;
        end
    end

    ifetch_buf #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_pc_i   (reqPc_q),
        .push_inst_i (rom_dout),
        .count_o     (bufCount),
        .head_valid_o(headValid),
        .head_pc_o   (inst_pc),
        .head_inst_o (inst)
    );

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage directly upstream of the instruction ROM. It owns the program counter and issues word addresses to the ROM's `addr`/`ready` inputs. It captures the ROM's one-cycle-latency `dout`/`valid` response into a 2-entry buffer and presents `{pc, instruction}` pairs to decode over a valid/ready handshake. It also handles redirects from branch/jump resolution by flushing buffered and in-flight instructions.

## Interface
- `AWIDTH`, default 16: PC / ROM address width, in words.
- `DWIDTH`, default 16: instruction width.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `fetch_en`  in  1  fetch permitted. When low, no new ROM requests are issued; buffer contents and the in-flight response are kept.
- `redirect_valid`  in  1  redirect pulse. Flush and restart fetching at `redirect_pc`.
- `redirect_pc`  in  AWIDTH  redirect target.
- `rom_addr`  out  AWIDTH  ROM word address.
- `rom_ready`  out  1  ROM request strobe. The ROM responds on the next cycle.
- `rom_dout`  in  DWIDTH  ROM data. Meaningful when `rom_valid`=1.
- `rom_valid`  in  1  ROM response valid. Equals `rom_ready` delayed one cycle.
- `inst`  out  DWIDTH  instruction to decode.
- `inst_pc`  out  AWIDTH  address of `inst`.
- `inst_valid`  out  1  `inst`/`inst_pc` valid.
- `inst_ready`  in  1  decode accepts. A transfer (pop) occurs when `inst_valid & inst_ready`.

## Operation
- **State:**
  - `pc` (next address to request).
  - 2-entry FIFO of `{pc, inst}` with `count` ∈ {0, 1, 2}.
  - `req_pc` register holding the address of the request issued last cycle.
- **Push:** when `rom_valid`=1 and `redirect_valid`=0, write `{req_pc, rom_dout}` into the FIFO.
- **Issue condition:** `rom_ready = fetch_en & (redirect_valid | (count + push − pop ≤ 1))`. This guarantees the response always has a free slot, so no response is ever dropped except on redirect.
- **Issued address:** `rom_addr = redirect_valid ? redirect_pc : pc`.
- **On issue:**
  - `req_pc <= rom_addr`.
  - `pc <= rom_addr + 1`, wrapping modulo 2^AWIDTH (0xFFFF → 0x0000 at the default width).
- **Redirect cycle:**
  - `inst_valid` is forced to 0, so no pop occurs.
  - The FIFO is cleared (`count <= 0`).
  - `rom_valid` in this cycle is discarded, since it belongs to the old stream.
  - `redirect_pc` is issued in the same cycle if `fetch_en`=1.
  - If `fetch_en`=0, then `pc <= redirect_pc` instead.
- **Simultaneous push and pop:** `count` is unchanged; FIFO order is preserved.
- **`fetch_en` low:** a response already in flight is still pushed normally.
- **Reset:** the following values hold asynchronously while `rst_n`=0.
  - Internal state: `pc = RESET_PC`, `count = 0`, `req_pc = 0`.
  - Outputs: `inst_valid = 0`, `inst = 0`, `inst_pc = 0`.
  - `rom_ready` is forced to 0 while in reset.
  - A ROM response arriving in the first cycle after reset release is ignored, because it is gated by a registered "issued-since-reset" bit.

## Timing
- Request at cycle t → `rom_valid` at t+1 → `inst_valid` at t+2 (registered FIFO head).
- Reset released before edge 0, `fetch_en`=1:
  - cycle 0 issues `RESET_PC`;
  - cycle 1 issues `RESET_PC`+1;
  - the first `inst_valid` appears at cycle 2.
- With `inst_ready` held at 1: one instruction per cycle, no bubbles in steady state.
- Redirect at cycle r: `inst_valid`=0 at cycles r, r+1; the target instruction is visible at r+2.
- Combinational paths: `inst_ready` → `rom_ready`, and `redirect_*` → `rom_addr`/`rom_ready`. Both are accepted; no combinational path exists from `rom_*` inputs to outputs.

## Structure
- **Shared package/header:** default `AWIDTH`/`DWIDTH`, `RESET_PC`, and the FIFO depth constant (2). These are shared with `irom` and decode.
- **Sub-module `ifetch_buf`:** a 2-entry synchronous FIFO with `push`, `pop`, `flush`, `count`, and head outputs. It is registered and reset asynchronously.
- The top level contains the PC register, `req_pc`, the issue logic and the redirect logic.

## Test plan
- **Streaming:**
  - Stimulus: ROM word[i]=0x1000+i, `inst_ready`=1 throughout.
  - Required: `inst_pc` 0,1,2,… from cycle 2 onward, with `inst` = 0x1000+`inst_pc`, no gaps.
- **Backpressure:**
  - Stimulus: `inst_ready`=0 for cycles 3–8.
  - Required: `count` reaches 2, `rom_ready`=0 while full, no instruction lost or duplicated after release.
- **Redirect with full FIFO and response in flight:**
  - Stimulus: `redirect_pc`=0x0040.
  - Required: the next `inst_pc` seen is 0x0040 (at r+2), followed by 0x0041; no old-stream instruction appears.
- **Wrap-around:**
  - Stimulus: redirect to 0xFFFE.
  - Required: `inst_pc` sequence 0xFFFE, 0xFFFF, 0x0000.
- **`fetch_en` toggling:**
  - Stimulus: `fetch_en`=0 for 3 cycles mid-stream, including a redirect during that window.
  - Required: no requests while low; on resume, the first request is `redirect_pc`.
- **Reset mid-stream:**
  - Stimulus: assert `rst_n`=0 asynchronously while full.
  - Required: `inst_valid`=0 immediately; after release, fetch restarts at `RESET_PC`; the stale `rom_valid` is ignored.
